setpoint_error_generator: RTL
=============================

SETPOINT_ERROR_GENERATOR -- requirements
Module: setpoint_error_generator

Interface
REQ-001 SHALL have parameter STEP_LIMIT, default 32'sd50: the maximum change of desired_pos per tick.
REQ-002 SHALL have parameter SETTLE_BAND, default 32'sd100: the in-position error magnitude limit.
REQ-003 SHALL have parameter SETTLE_TICKS, default 8'd20: the number of consecutive in-band ticks required for completion.
REQ-004 clk  input  1  single system clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clk_100k_enable  input  1  one-clk tick strobe; all "tick" actions below SHALL occur only on clk edges where this is high.
REQ-007 cmd_valid  input  1  new target offered.
REQ-008 cmd_ready  output  1  block accepts a target; combinational, high exactly in state IDLE.
REQ-009 cmd_target  input  32 signed  target position.
REQ-010 abort  input  1  cancel the current move.
REQ-011 actual_pos  input  32 signed  encoder position.
REQ-012 desired_pos  output  32 signed  ramped setpoint.
REQ-013 error_pos  output  32 signed  desired minus actual, saturated.
REQ-014 prev_error  output  32 signed  error_pos from the previous tick.
REQ-015 err_valid  output  1  one-clk pulse on the clk after each tick update.
REQ-016 move_active  output  1  high in RAMP or SETTLE.
REQ-017 move_done  output  1  one-clk completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, RAMP and SETTLE.
REQ-019 IDLE: on cmd_valid&&cmd_ready at any clk edge (not tick-gated), SHALL latch cmd_target into the internal target register and move to RAMP.
REQ-020 RAMP, per tick: diff = target - desired_pos computed in 33 bits; if |diff| <= STEP_LIMIT, desired_pos <= target and the FSM enters SETTLE; otherwise desired_pos <= desired_pos + STEP_LIMIT when diff > 0, else desired_pos - STEP_LIMIT.
REQ-021 SETTLE, per tick: if |error_pos value computed this tick| <= SETTLE_BAND, the settle counter SHALL increment, else clear to 0; when the counter reaches SETTLE_TICKS, move_done SHALL pulse for one clk, the counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-022 On every tick, in all states: prev_error <= error_pos; error_pos <= sat32(desired_pos_pre - actual_pos).
  - desired_pos_pre is the register value before this tick's ramp update.
  - sat32 is a 33-bit subtraction clamped to [-2^31+1, 2^31-1].
REQ-023 err_valid SHALL be high exactly one clk after each tick, in all states.
REQ-024 abort in RAMP or SETTLE SHALL freeze desired_pos, clear the settle counter, return the FSM to IDLE on the same edge, and produce no move_done.
REQ-025 abort SHALL win over a coincident tick for FSM and desired_pos purposes; the error pipeline of REQ-022 still updates on that tick.
REQ-026 abort in IDLE SHALL be ignored; abort and cmd_valid together in IDLE SHALL accept the command.
REQ-027 cmd_valid SHALL be ignored outside IDLE, because cmd_ready is low there.
REQ-028 A target equal to desired_pos SHALL enter SETTLE on the first RAMP tick.
REQ-029 The |diff| and |error| comparisons SHALL be done in 33 bits so that a value of -2^31 never wraps.

Reset
REQ-030 While reset is high: state = IDLE; desired_pos, target, error_pos, prev_error and the settle counter = 0; err_valid, move_done and move_active = 0; cmd_ready = 1.
REQ-031 A reset mid-move SHALL abandon the move without a move_done pulse.
REQ-032 After reset is released, the first tick SHALL produce error_pos = -actual_pos (saturated) and prev_error = 0.

Verification
REQ-033 Ramp test: actual_pos=0, accept target 120, apply ticks 1..3 -> desired_pos 50, 100, 120; SETTLE entered on tick 3; error_pos after ticks 2..4 = 50, 100, 120.
REQ-034 Settle test: from SETTLE with actual_pos = desired_pos, apply 20 ticks -> move_done pulses once, one clk wide, after the 20th tick; cmd_ready goes high.
REQ-035 Band-break test: in SETTLE, apply 19 in-band ticks, then |error| = 101 for one tick, then 20 in-band ticks -> move_done only after the last of the 20.
REQ-036 Negative/abort test: target -200, abort on the same edge as tick 2 -> desired_pos held at -50, IDLE, move_done never pulses, err_valid still pulses.
REQ-037 Saturation test: desired_pos = 2^31-1 and actual_pos = -10 -> error_pos = 2^31-1; swapped signs -> error_pos = -2^31+1.
REQ-038 Reset test: assert reset mid-RAMP -> all outputs at REQ-030 values immediately and asynchronously; a new command is accepted one clk after release.

Source files
------------

// File: rtl/setpoint_error_generator.sv
// setpoint_error_generator
//
// Ramps an internal position setpoint (desired_pos) toward an accepted target
// by at most STEP_LIMIT per tick, produces a saturated following error
// against the encoder position, and reports completion once the error has
// stayed inside SETTLE_BAND for SETTLE_TICKS consecutive ticks.
//
// Ports
//   clk              system clock, all state updates on its rising edge
//   reset            asynchronous, active-high reset
//   clk_100k_enable  one-clk tick strobe; ramp/settle/error updates use it
//   cmd_valid        new target offered
//   cmd_ready        target accepted this clk (high exactly in IDLE)
//   cmd_target       signed target position
//   abort            cancel the current move (ignored in IDLE)
//   actual_pos       signed encoder position
//   desired_pos      ramped setpoint
//   error_pos        desired_pos - actual_pos, saturated to +/-(2^31-1)
//   prev_error       error_pos from the previous tick
//   err_valid        one-clk pulse after each tick update
//   move_active      high in RAMP or SETTLE
//   move_done        one-clk pulse when a move completes
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high
// RAMP   | stepping desired_pos toward target by STEP_LIMIT per tick
// SETTLE | desired_pos at target; counting consecutive in-band ticks

module setpoint_error_generator #(
    parameter logic signed [31:0] STEP_LIMIT   = 32'sd50,
    parameter logic signed [31:0] SETTLE_BAND  = 32'sd100,
    parameter logic        [7:0]  SETTLE_TICKS = 8'd20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_100k_enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [31:0] cmd_target,
    input  logic               abort,
    input  logic signed [31:0] actual_pos,
    output logic signed [31:0] desired_pos,
    output logic signed [31:0] error_pos,
    output logic signed [31:0] prev_error,
    output logic               err_valid,
    output logic               move_active,
    output logic               move_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Wide copies of the limits so the magnitude compares never wrap,
    // even when a difference involves -2^31.
    localparam logic signed [33:0] STEP_X = 34'(STEP_LIMIT);
    localparam logic signed [32:0] BAND_X = 33'(SETTLE_BAND);
    localparam logic signed [32:0] SAT_HI = 33'sd2147483647;
    localparam logic signed [32:0] SAT_LO = -33'sd2147483647;

    state_t             state;
    state_t             state_nxt;
    logic signed [31:0] target;
    logic signed [31:0] target_nxt;
    logic signed [31:0] desired_nxt;
    logic signed [31:0] error_nxt;
    logic        [7:0]  settle_cnt;
    logic        [7:0]  cnt_nxt;
    logic        [7:0]  cnt_inc;
    logic               done_nxt;
    logic signed [33:0] diff;
    logic signed [33:0] diff_abs;
    logic signed [32:0] err_raw;
    logic signed [32:0] err_abs;

    assign cmd_ready   = (state == IDLE);
    assign move_active = (state != IDLE);

    // Arithmetic shared by the FSM and the error pipeline. The error uses
    // desired_pos before this tick's ramp step.
    always_comb begin
        diff     = 34'(target) - 34'(desired_pos);
        diff_abs = diff[33] ? -diff : diff;
        err_raw  = 33'(desired_pos) - 33'(actual_pos);
        if (err_raw > SAT_HI) begin
            error_nxt = 32'sh7FFF_FFFF;
        end else if (err_raw < SAT_LO) begin
            error_nxt = 32'sh8000_0001;
        end else begin
            error_nxt = err_raw[31:0];
        end
        err_abs = error_nxt[31] ? -33'(error_nxt) : 33'(error_nxt);
        cnt_inc = settle_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        desired_nxt = desired_pos;
        cnt_nxt     = settle_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // Command acceptance is not tick-gated; abort is ignored here.
                if (cmd_valid) begin
                    target_nxt = cmd_target;
                    state_nxt  = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else if (clk_100k_enable) begin
                    if (diff_abs <= STEP_X) begin
                        desired_nxt = target;
                        state_nxt   = SETTLE;
                    end else if (!diff[33]) begin
                        desired_nxt = desired_pos + STEP_LIMIT;
                    end else begin
                        desired_nxt = desired_pos - STEP_LIMIT;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else if (clk_100k_enable) begin
                    if (err_abs <= BAND_X) begin
                        if (cnt_inc >= SETTLE_TICKS) begin
                            cnt_nxt   = 8'd0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = 8'd0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target      <= 32'sd0;
            desired_pos <= 32'sd0;
            settle_cnt  <= 8'd0;
            move_done   <= 1'b0;
            err_valid   <= 1'b0;
            error_pos   <= 32'sd0;
            prev_error  <= 32'sd0;
        end else begin
            target      <= target_nxt;
            desired_pos <= desired_nxt;
            settle_cnt  <= cnt_nxt;
            move_done   <= done_nxt;
            err_valid   <= clk_100k_enable;
            // The error pipeline runs on every tick, abort or not.
            if (clk_100k_enable) begin
                prev_error <= error_pos;
                error_pos  <= error_nxt;
            end
        end
    end

endmodule
